// File: rtl/client_limit_checker.sv
// client_limit_checker
//   Per-client pre-trade risk gate. Each client ID has a max-to-trade limit and
//   an accumulated-order total. Each order is checked against its client's
//   limit, and the quantity is committed only when the order is accepted.
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     cfg_we/cfg_addr/cfg_max         write a client's limit (RUN only)
//     cfg_clr_acc                     with cfg_we: also zero that client's acc
//     ord_valid/ord_ready             order handshake (ready = RUN & ~cfg_we)
//     ord_client/ord_qty              order payload
//     rsp_valid/accept/client/acc     decision, 2 cycles after handshake
//     init_done                       table sweep finished
//     rej_cnt                         saturating rejected-order count
//
//   Optional build macro: REJECT_CNT_EN. When it is undefined, rej_cnt is
//   tied to 0.
//
//   The table is held in flops and read in S2, which is the same cycle the
//   commit is written back. Every decision therefore sees all earlier commits
//   and config writes. No forwarding muxes are needed, including for
//   back-to-back orders to the same client.
module client_limit_checker #(
  parameter int A_WIDTH   = 5,
  parameter int CLIENTS   = 2**A_WIDTH,
  parameter int Q_WIDTH   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [A_WIDTH-1:0]   cfg_addr,
  input  logic [Q_WIDTH-1:0]   cfg_max,
  input  logic                 cfg_clr_acc,
  input  logic                 ord_valid,
  output logic                 ord_ready,
  input  logic [A_WIDTH-1:0]   ord_client,
  input  logic [Q_WIDTH-1:0]   ord_qty,
  output logic                 rsp_valid,
  output logic                 rsp_accept,
  output logic [A_WIDTH-1:0]   rsp_client,
  output logic [Q_WIDTH-1:0]   rsp_acc,
  output logic                 init_done,
  output logic [CNT_WIDTH-1:0] rej_cnt
);

  localparam int STAGES = 2;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(CLIENTS-1);
  localparam logic [A_WIDTH:0]   N_CLIENTS = (A_WIDTH+1)'(CLIENTS);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [A_WIDTH-1:0] client;
    logic [Q_WIDTH-1:0] qty;
  } ord_req_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] init_addr;
  logic [STAGES:1]    vld_pipe;
  ord_req_t           s1_req;

  logic [Q_WIDTH-1:0] max_tab [CLIENTS];
  logic [Q_WIDTH-1:0] acc_tab [CLIENTS];

  logic               ord_take, s1_in, cfg_do, accept, commit;
  logic [Q_WIDTH-1:0] cur_max, cur_acc;
  logic [Q_WIDTH:0]   sum;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_addr == LAST_ADDR) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 init_addr <= '0;
    else if (state_q == INIT)   init_addr <= init_addr + 1'b1;
  end

  assign init_done = (state_q == RUN);
  assign ord_ready = (state_q == RUN) & ~cfg_we;
  assign ord_take  = ord_valid & ord_ready;

  // ---------------- S1: request register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_req   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], ord_take};
      if (ord_take) s1_req <= '{client: ord_client, qty: ord_qty};
    end
  end

  // ---------------- S2: decision ----------------
  assign s1_in   = {1'b0, s1_req.client} < N_CLIENTS;
  assign cur_max = s1_in ? max_tab[s1_req.client] : '0;
  assign cur_acc = s1_in ? acc_tab[s1_req.client] : '0;
  // The extra bit catches carry-out, so an overflowing sum is rejected
  // rather than wrapped.
  assign sum     = {1'b0, cur_acc} + {1'b0, s1_req.qty};
  // A zero quantity changes nothing, so it passes even when acc > max.
  assign accept  = s1_in & ((s1_req.qty == '0) | (sum <= {1'b0, cur_max}));
  assign commit  = vld_pipe[1] & accept;
  assign cfg_do  = (state_q == RUN) & cfg_we & ({1'b0, cfg_addr} < N_CLIENTS);

  // Table write. Statement order sets the priority: a config write lands
  // after the commit, so a clear beats a same-cycle commit, while a
  // plain limit write leaves the committed acc in place.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      max_tab[init_addr] <= '0;
      acc_tab[init_addr] <= '0;
    end else begin
      if (commit) acc_tab[s1_req.client] <= sum[Q_WIDTH-1:0];
      if (cfg_do) begin
        max_tab[cfg_addr] <= cfg_max;
        if (cfg_clr_acc) acc_tab[cfg_addr] <= '0;
      end
    end
  end

  // ---------------- response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_accept <= 1'b0;
      rsp_client <= '0;
      rsp_acc    <= '0;
    end else if (vld_pipe[1]) begin
      rsp_accept <= accept;
      rsp_client <= s1_req.client;
      rsp_acc    <= accept ? sum[Q_WIDTH-1:0] : cur_acc;
    end
  end

  assign rsp_valid = vld_pipe[STAGES];

`ifdef REJECT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rej_cnt <= '0;
    else if (rsp_valid && !rsp_accept && !(&rej_cnt))
      rej_cnt <= rej_cnt + 1'b1;
  end
`else
  assign rej_cnt = '0;
`endif

endmodule
